// File: rtl/lock_entry_controller.sv
// -----------------------------------------------------------------------------
// lock_entry_controller
//
// Front-end sequencer between a raw 4-key keypad and the digitalLock core.
// It turns held key levels into single-cycle one-hot key pulses, aborts a
// partial entry that stalls for too long between digits, and counts
// consecutive failed codes, imposing a timed lockout during which every key
// is ignored.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low reset
//   key_raw[3:0]   synchronised keypad levels, 1 = pressed
//   lock_error     error level from the core, sampled RESULT_DELAY clocks
//                  after the last digit of a code
//   key_out[3:0]   one-hot, one-cycle key pulse to the core (0000 otherwise)
//   entry_abort    one-cycle pulse telling the core to drop a partial entry
//   lockout        high for the whole lockout period
//   attempts_left  MAX_ATTEMPTS minus the consecutive-failure count
//   digit_count    digits accepted in the current entry
//   busy           high while waiting for the result and during lockout
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module lock_entry_controller #(
    parameter int PASSCODE_LENGTH      = 3,
    parameter int ENTRY_TIMEOUT_CYCLES = 250000000,
    parameter int LOCKOUT_CYCLES       = 1500000000,
    parameter int MAX_ATTEMPTS         = 3,
    parameter int RESULT_DELAY         = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_raw,
    input  logic       lock_error,
    output logic [3:0] key_out,
    output logic       entry_abort,
    output logic       lockout,
    output logic [1:0] attempts_left,
    output logic [1:0] digit_count,
    output logic       busy
);

    // One shared timer serves the entry timeout, the result delay and the
    // lockout; it is sized for the longest of the three.
    localparam int TMAX_A  = (ENTRY_TIMEOUT_CYCLES > LOCKOUT_CYCLES) ?
                             ENTRY_TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX    = (TMAX_A > RESULT_DELAY) ? TMAX_A : RESULT_DELAY;
    localparam int TIMER_W = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int FAIL_W  = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;

    localparam logic [TIMER_W-1:0] ENTRY_LAST   = TIMER_W'(ENTRY_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LAST  = TIMER_W'(RESULT_DELAY - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  FAIL_LAST    = FAIL_W'(MAX_ATTEMPTS - 1);
    localparam logic [1:0]         ATT_MAX      = 2'(MAX_ATTEMPTS);
    localparam logic [1:0]         LAST_DIGIT   = 2'(PASSCODE_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ENTRY       = 2'd1,
        ST_WAIT_RESULT = 2'd2,
        ST_LOCKOUT     = 2'd3
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [3:0] v);
        is_one_hot = (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    state_t              state_r;
    logic [3:0]          prev_key_r;
    logic [TIMER_W-1:0]  timer_r;
    logic [FAIL_W-1:0]   fail_cnt_r;
    logic [3:0]          key_out_r;
    logic                entry_abort_r;
    logic                lockout_r;
    logic [1:0]          attempts_left_r;
    logic [1:0]          digit_count_r;
    logic                busy_r;
    logic                valid_press_s;

    // A press counts only on a clean edge from all-released to a single key;
    // prev_key_r tracks key_raw in every state, so a key held across a state
    // change (e.g. lockout exit) must be released before it is accepted.
    always_comb begin
        valid_press_s = 1'b0;
        if (is_one_hot(key_raw) && (prev_key_r == 4'b0000)) begin
            valid_press_s = 1'b1;
        end else begin
            valid_press_s = 1'b0;
        end
    end

    // Entry / result / lockout sequencer with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            prev_key_r      <= 4'b0000;
            timer_r         <= '0;
            fail_cnt_r      <= '0;
            key_out_r       <= 4'b0000;
            entry_abort_r   <= 1'b0;
            lockout_r       <= 1'b0;
            attempts_left_r <= ATT_MAX;
            digit_count_r   <= 2'd0;
            busy_r          <= 1'b0;
        end else begin
            prev_key_r    <= key_raw;
            key_out_r     <= 4'b0000;
            entry_abort_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    timer_r <= '0;
                    if (valid_press_s) begin
                        key_out_r     <= key_raw;
                        digit_count_r <= 2'd1;
                        if (PASSCODE_LENGTH == 1) begin
                            state_r <= ST_WAIT_RESULT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ENTRY;
                        end
                    end
                end

                ST_ENTRY: begin
                    // A press on the timeout cycle wins over the abort.
                    if (valid_press_s) begin
                        key_out_r     <= key_raw;
                        digit_count_r <= digit_count_r + 2'd1;
                        timer_r       <= '0;
                        if (digit_count_r == LAST_DIGIT) begin
                            state_r <= ST_WAIT_RESULT;
                            busy_r  <= 1'b1;
                        end
                    end else if (timer_r == ENTRY_LAST) begin
                        entry_abort_r <= 1'b1;
                        digit_count_r <= 2'd0;
                        timer_r       <= '0;
                        state_r       <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end

                ST_WAIT_RESULT: begin
                    if (timer_r == RESULT_LAST) begin
                        timer_r       <= '0;
                        digit_count_r <= 2'd0;
                        if (lock_error) begin
                            // Lockout is entered on reaching the limit, so
                            // the count can never pass MAX_ATTEMPTS.
                            if (fail_cnt_r >= FAIL_LAST) begin
                                fail_cnt_r      <= FAIL_W'(MAX_ATTEMPTS);
                                attempts_left_r <= 2'd0;
                                lockout_r       <= 1'b1;
                                state_r         <= ST_LOCKOUT;
                            end else begin
                                fail_cnt_r      <= fail_cnt_r + 1'b1;
                                attempts_left_r <= attempts_left_r - 2'd1;
                                busy_r          <= 1'b0;
                                state_r         <= ST_IDLE;
                            end
                        end else begin
                            fail_cnt_r      <= '0;
                            attempts_left_r <= ATT_MAX;
                            busy_r          <= 1'b0;
                            state_r         <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer_r == LOCKOUT_LAST) begin
                        timer_r         <= '0;
                        fail_cnt_r      <= '0;
                        attempts_left_r <= ATT_MAX;
                        lockout_r       <= 1'b0;
                        busy_r          <= 1'b0;
                        state_r         <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    timer_r       <= '0;
                    digit_count_r <= 2'd0;
                    lockout_r     <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign key_out       = key_out_r;
    assign entry_abort   = entry_abort_r;
    assign lockout       = lockout_r;
    assign attempts_left = attempts_left_r;
    assign digit_count   = digit_count_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_lock_entry_controller.sv
// -----------------------------------------------------------------------------
// tb_lock_entry_controller
//
// Directed bench for lock_entry_controller with PASSCODE_LENGTH=3,
// ENTRY_TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=50, MAX_ATTEMPTS=3, RESULT_DELAY=2.
// A vector table covers single-cycle behaviour; hand-written sequences cover
// timeout, lockout and asynchronous reset.
// Observed bundle layout: {key_out, entry_abort, lockout, attempts_left,
// digit_count, busy}.
// -----------------------------------------------------------------------------
module tb_lock_entry_controller;

    logic       clock;
    logic       reset;
    logic [3:0] key_raw;
    logic       lock_error;
    logic [3:0] key_out;
    logic       entry_abort;
    logic       lockout;
    logic [1:0] attempts_left;
    logic [1:0] digit_count;
    logic       busy;

    logic [10:0] obs;
    int          tests_run;
    int          tests_failed;

    lock_entry_controller #(
        .PASSCODE_LENGTH     (3),
        .ENTRY_TIMEOUT_CYCLES(20),
        .LOCKOUT_CYCLES      (50),
        .MAX_ATTEMPTS        (3),
        .RESULT_DELAY        (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_raw      (key_raw),
        .lock_error   (lock_error),
        .key_out      (key_out),
        .entry_abort  (entry_abort),
        .lockout      (lockout),
        .attempts_left(attempts_left),
        .digit_count  (digit_count),
        .busy         (busy)
    );

    assign obs = {key_out, entry_abort, lockout, attempts_left, digit_count, busy};

    // 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [3:0] key;
        logic       err;
        logic [3:0] exp_key;
        logic [1:0] exp_dc;
        logic       exp_busy;
        logic [1:0] exp_att;
    } vec_t;

    vec_t vecs [23];

    function automatic logic [10:0] pack(input logic [3:0] k, input logic ab,
                                         input logic lo, input logic [1:0] att,
                                         input logic [1:0] dc, input logic bz);
        return {k, ab, lo, att, dc, bz};
    endfunction

    task automatic chk(input string name, input logic [10:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b (key|abort|lockout|att|dc|busy) t=%0t",
                     name, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and return just after the rising edge.
    task automatic step(input logic [3:0] k, input logic e);
        key_raw    = k;
        lock_error = e;
        @(posedge clock);
        #1;
    endtask

    task automatic setv(input int i, input logic [3:0] k, input logic e,
                        input logic [3:0] ek, input logic [1:0] edc,
                        input logic eb, input logic [1:0] ea);
        vecs[i].key      = k;
        vecs[i].err      = e;
        vecs[i].exp_key  = ek;
        vecs[i].exp_dc   = edc;
        vecs[i].exp_busy = eb;
        vecs[i].exp_att  = ea;
    endtask

    // Three digits with lock_error held, followed by the result wait.
    task automatic enter_code(input logic [3:0] k1, input logic [3:0] k2,
                              input logic [3:0] k3, input logic e);
        step(k1, e);
        step(4'b0000, e);
        step(k2, e);
        step(4'b0000, e);
        step(k3, e);
        step(4'b0000, e);
        step(4'b0000, e);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        key_raw      = 4'b0000;
        lock_error   = 1'b0;

        // key, err, exp key_out, exp digit_count, exp busy, exp attempts_left
        setv(0,  4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd3);
        setv(1,  4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(2,  4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(3,  4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(4,  4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(5,  4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(6,  4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(7,  4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, 2'd3);
        setv(8,  4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd3);
        setv(9,  4'b0001, 1'b0, 4'b0001, 2'd3, 1'b1, 2'd3);
        setv(10, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd3);
        setv(11, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);
        setv(12, 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);
        setv(13, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);
        setv(14, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);
        setv(15, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);
        setv(16, 4'b1000, 1'b1, 4'b1000, 2'd1, 1'b0, 2'd3);
        setv(17, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd3);
        setv(18, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd3);
        setv(19, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd3);
        setv(20, 4'b0010, 1'b1, 4'b0010, 2'd3, 1'b1, 2'd3);
        setv(21, 4'b0001, 1'b1, 4'b0000, 2'd3, 1'b1, 2'd3);
        setv(22, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd2);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        @(negedge clock);
        reset = 1'b1;

        // Table: held key, multi-key, good code, failed code
        for (int i = 0; i < 23; i++) begin
            step(vecs[i].key, vecs[i].err);
            chk($sformatf("vec%0d", i),
                pack(vecs[i].exp_key, 1'b0, 1'b0, vecs[i].exp_att,
                     vecs[i].exp_dc, vecs[i].exp_busy));
        end

        // Entry timeout: abort 20 cycles after the accepted digit
        step(4'b0001, 1'b0);
        chk("to_press", pack(4'b0001, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0));
        for (int i = 1; i < 20; i++) begin
            step(4'b0000, 1'b0);
            chk($sformatf("to_wait%0d", i), pack(4'b0000, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0));
        end
        step(4'b0000, 1'b0);
        chk("to_abort", pack(4'b0000, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0));
        step(4'b0000, 1'b0);
        chk("to_abort_once", pack(4'b0000, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0));

        // Press on the timeout cycle wins and restarts the timer
        step(4'b0001, 1'b0);
        chk("tp_press1", pack(4'b0001, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0));
        for (int i = 1; i < 20; i++) begin
            step(4'b0000, 1'b0);
        end
        step(4'b0010, 1'b0);
        chk("tp_press_wins", pack(4'b0010, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0));
        for (int i = 1; i < 20; i++) begin
            step(4'b0000, 1'b0);
            chk($sformatf("tp_wait%0d", i), pack(4'b0000, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0));
        end
        step(4'b0000, 1'b0);
        chk("tp_abort", pack(4'b0000, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0));

        // Good code clears the fail count, then three failures lock out
        enter_code(4'b0001, 4'b0010, 4'b0100, 1'b0);
        chk("good_code", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        enter_code(4'b1000, 4'b1000, 4'b1000, 1'b1);
        chk("fail1", pack(4'b0000, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0));
        enter_code(4'b1000, 4'b0100, 4'b1000, 1'b1);
        chk("fail2", pack(4'b0000, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
        enter_code(4'b0001, 4'b0100, 4'b1000, 1'b1);
        chk("fail3_lockout", pack(4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));

        // Presses during lockout are ignored; key held across exit
        for (int i = 1; i < 49; i++) begin
            step((i % 2 == 1) ? 4'b0001 : 4'b0000, 1'b0);
            chk($sformatf("lk%0d", i), pack(4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
        end
        step(4'b0100, 1'b0);
        chk("lk49", pack(4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
        step(4'b0100, 1'b0);
        chk("lk_exit", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        step(4'b0100, 1'b0);
        chk("lk_held_key", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        chk("lk_after_release", pack(4'b0100, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0));

        // Asynchronous reset mid-entry
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        chk("pre_rst_entry", pack(4'b0010, 1'b0, 1'b0, 2'd3, 2'd2, 1'b0));
        #2 reset = 1'b0;
        #1;
        chk("rst_entry_async", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        @(posedge clock);
        #1;
        chk("rst_entry_held", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        @(negedge clock);
        reset = 1'b1;

        // Asynchronous reset mid-lockout
        enter_code(4'b0001, 4'b0001, 4'b0001, 1'b1);
        enter_code(4'b0001, 4'b0001, 4'b0001, 1'b1);
        enter_code(4'b0001, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0);
        end
        chk("pre_rst_lockout", pack(4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
        #2 reset = 1'b0;
        #1;
        chk("rst_lockout_async", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        @(negedge clock);
        reset = 1'b1;
        step(4'b0000, 1'b0);
        chk("post_rst_idle", pack(4'b0000, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0));
        step(4'b1000, 1'b0);
        chk("post_rst_press", pack(4'b1000, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lock_entry_controller.md
Name: lock_entry_controller

Overview:
Front-end sequencer between the raw 4-key keypad and the digitalLock core.
- Converts held key levels into single-cycle one-hot key pulses.
- Enforces an inter-digit entry timeout; a stalled partial entry is aborted.
- Counts consecutive failed codes and imposes a timed lockout, during which all keys are ignored.

Parameters:
PASSCODE_LENGTH, 3, digits per code; must match the core.
ENTRY_TIMEOUT_CYCLES, 250000000, maximum idle clocks between digits (5 s at 50 MHz).
LOCKOUT_CYCLES, 1500000000, lockout duration in clocks (30 s at 50 MHz).
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout.
RESULT_DELAY, 2, clocks after the last digit before the core's error output is sampled.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
key_raw  input  4  synchronised keypad levels; 1 = pressed.
lock_error  input  1  error level from the core.
key_out  output  4  one-hot, one-cycle key pulse to the core; 0000 otherwise.
entry_abort  output  1  one-cycle pulse telling the core to discard a partial entry.
lockout  output  1  high throughout the lockout period.
attempts_left  output  2  equals MAX_ATTEMPTS minus the consecutive-failure count.
digit_count  output  2  digits accepted in the current entry.
busy  output  1  high in WAIT_RESULT and LOCKOUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; key_out=0000; entry_abort=0; lockout=0; busy=0.
  - attempts_left=MAX_ATTEMPTS; digit_count=0; all timers are 0.
- Valid press: key_raw is exactly one-hot AND the registered previous key_raw is 0000.
  - Multi-key patterns are ignored.
  - Holding a key yields one press only.
  - A new press requires a full release first.
- key_out is registered: it is asserted the cycle after the valid press is detected, and lasts 1 cycle.
- IDLE:
  - A valid press issues key_out and sets digit_count=1.
  - Next state is ENTRY, or WAIT_RESULT if PASSCODE_LENGTH=1.
- ENTRY:
  - The timer increments every clock.
  - A valid press issues key_out, increments digit_count and clears the timer.
  - When digit_count reaches PASSCODE_LENGTH, the next state is WAIT_RESULT and the timer clears.
  - If the timer reaches ENTRY_TIMEOUT_CYCLES-1 with no press: pulse entry_abort for 1 cycle, set digit_count=0, go to IDLE.
  - Simultaneous timeout and valid press: the press wins, the timer clears, and no abort is issued.
- WAIT_RESULT:
  - busy=1 and key_raw is ignored (no pulses).
  - After RESULT_DELAY clocks, lock_error is sampled:
    - error=1: fail count +1. If the count is now MAX_ATTEMPTS, go to LOCKOUT; otherwise go to IDLE.
    - error=0: fail count = 0, go to IDLE.
  - digit_count=0 on exit.
- LOCKOUT:
  - lockout=1, busy=1, keys ignored, timer counts.
  - At LOCKOUT_CYCLES-1: fail count = 0 (attempts_left=MAX_ATTEMPTS), lockout=0, go to IDLE.
  - A key held across lockout exit is not accepted until it is released.
- Counter widths: timers are sized by $clog2 of their parameter. The fail count saturates at MAX_ATTEMPTS and never wraps.
- Reset asserted mid-entry or mid-lockout returns to the reset state immediately; no entry_abort pulse is issued.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use PASSCODE_LENGTH=3, ENTRY_TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=50, MAX_ATTEMPTS=3, RESULT_DELAY=2.
1. Hold key_raw=0010 for 6 cycles, release, then press 0100 for 1 cycle -> exactly two key_out pulses (0010, 0100), each 1 cycle wide and 1 cycle after the press edge; digit_count=2.
2. Press 0011, then 1111 -> no key_out pulse; digit_count stays 0; state stays IDLE.
3. Enter 1 digit, then idle 20 cycles -> entry_abort pulses once, 20 cycles after the digit was accepted; digit_count=0. A press on the timeout cycle instead clears the timer with no abort.
4. Enter 3 digits with lock_error=0 -> busy=1 for 2 cycles, attempts_left stays 3, return to IDLE. Repeat with lock_error=1 -> attempts_left=2.
5. Enter three failed codes -> lockout=1 after the third. Presses during the 50-cycle lockout produce no key_out. On exit: attempts_left=3, lockout=0.
6. Assert reset=0 mid-entry (digit_count=2) and mid-lockout -> all outputs take their reset values asynchronously, with no entry_abort pulse.
